pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised, elastic pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces fixed-field, stall-only stage registers with a generic payload, a valid/ready handshake, a two-entry skid buffer for full throughput, and a flush that turns the stage into a bubble.
- Control bits are kept separate from data so a bubble always presents inert control (no register or memory writes) downstream.

Parameters:
- DATA_W, 128, width of datapath payload (operands, imm, PC, register indices); never zeroed on bubble.
- CTRL_W, 12, width of control payload (ALU ctrl, ALU src, MEM wen, WB sel, Reg WB, auipc); forced to 0 whenever out_valid=0.
- RESET_DATA, 0, value loaded into both entries' data fields on reset and flush.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- flush  in  1  squash all held entries (branch/jump redirect).
- out_valid  out  1  main entry holds a valid instruction.
- out_ready  in  1  downstream accepts this cycle (0 = downstream stall).
- out_data  out  DATA_W  main entry datapath payload.
- out_ctrl  out  CTRL_W  main entry control payload, 0 when out_valid=0.
- occupancy  out  2  number of valid entries (0, 1 or 2).

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset: state EMPTY; both entries' data = RESET_DATA, ctrl = 0, valid = 0. Outputs: out_valid=0, out_ctrl=0, out_data=RESET_DATA, occupancy=0, in_ready=0 while reset is high and 1 on the first cycle after.
- Handshakes:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_ready = ~reset & (state != FULL). It depends on registered state only, never combinationally on out_ready.
- Entries: main (drives outputs) and skid. Latency 1 cycle (in_fire at cycle N gives out_valid at N+1). Sustained throughput 1 per cycle when out_ready=1.
- States (occupancy encodes state: EMPTY=0, ONE=1, FULL=2):
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE: in_fire & out_fire -> ONE, main<=in. in_fire & ~out_ready -> FULL, skid<=in, main unchanged. ~in_fire & out_fire -> EMPTY. Otherwise hold.
  - FULL: in_ready=0. out_fire -> ONE, main<=skid, skid cleared. Otherwise hold.
- Ordering: strictly FIFO; an entry is never dropped or duplicated except by flush/reset.
- Flush:
  - Priority is reset > flush > handshake.
  - On flush: next state EMPTY, both valids 0, ctrl 0, data RESET_DATA.
  - An in_fire in the flush cycle is discarded, as is any out_fire already signalled (downstream has consumed it that cycle).
- Hold: while out_ready=0 and out_valid=1, out_data and out_ctrl are stable (the downstream stall contract).
- Bubble: out_ctrl is the AND of the main ctrl register and out_valid. out_data keeps its last value when invalid.
- Simultaneous in_fire + out_fire in FULL cannot occur (in_ready=0). Assertion: never in_fire while state==FULL.

Decomposition:
- Shared package pipe_pkg: state encoding constants (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2) and default widths for each stage boundary (IF_ID_DATA_W, ID_EX_DATA_W, ID_EX_CTRL_W, ...).
- Sub-module pipe_slot: one entry (valid, data, ctrl) with load, clear and RESET_DATA. Instantiated twice (main, skid).

Test Plan:
- Reset then stream 0x11..0x18 with out_ready=1 -> outputs 0x11..0x18 one per cycle, first at cycle 1 after the first in_fire; occupancy stays 1.
- Accept 0xA1, 0xA2 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA1 held. Raise out_ready -> 0xA1 then 0xA2, in_ready returns to 1 the cycle after the first out_fire.
- FULL (0xB1, 0xB2) then flush=1 with in_valid=1 (0xB3) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xB3 never appears.
- Bubble check: in_ctrl=0xFFF with in_valid=0 for 3 cycles -> out_ctrl=0 throughout.
- Reset asserted while FULL with out_ready toggling -> next cycle occupancy=0, out_valid=0, out_data=RESET_DATA, in_ready=0 during reset, then 1.
- Random in_valid/out_ready (10k cycles, flush 1%) -> scoreboard: output sequence equals input sequence minus flushed entries; the FULL/in_fire assertion never fires.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers: state encoding
// (which doubles as the occupancy count) and default per-boundary widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Default payload widths for each inter-stage boundary.
  localparam int IF_ID_DATA_W  = 64;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_DATA_W  = 128;
  localparam int ID_EX_CTRL_W  = 12;
  localparam int EX_MEM_DATA_W = 112;
  localparam int EX_MEM_CTRL_W = 5;
  localparam int MEM_WB_DATA_W = 72;
  localparam int MEM_WB_CTRL_W = 3;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry (valid, data, ctrl). Reset/clear restore RESET_DATA,
// load captures a new entry, drop invalidates while keeping the data visible.
module pipe_slot #(
  parameter int                DATA_W     = 128,
  parameter int                CTRL_W     = 12,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      data  <= RESET_DATA;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end else if (drop) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready handshake, two-entry skid buffer for
// full throughput, flush-to-bubble, and control forced inert when invalid.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 128,
  parameter int                CTRL_W     = 12,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  state_e state_q, state_d;

  logic in_fire, out_fire;
  logic main_load, main_drop, main_from_skid;
  logic skid_load, skid_clear;
  logic skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_load_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_load_ctrl;

  // Ready comes from registered state only, never from out_ready.
  assign in_ready  = ~reset & (state_q != ST_FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state_q;
  assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end else if (out_fire) begin
          main_drop = 1'b1;
          state_d   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush squashes everything, including a same-cycle in_fire.
    if (flush) state_d = ST_EMPTY;
  end

  assign main_load_data = main_from_skid ? skid_data : in_data;
  assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_DATA(RESET_DATA)) u_main (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .load      (main_load),
    .drop      (main_drop),
    .load_data (main_load_data),
    .load_ctrl (main_load_ctrl),
    .valid     (out_valid),
    .data      (main_data),
    .ctrl      (main_ctrl)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_DATA(RESET_DATA)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush | skid_clear),
    .load      (skid_load),
    .drop      (1'b0),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .valid     (skid_valid),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );

  assign out_data = main_data;

  a_no_fire_when_full : assert property (@(posedge clk) disable iff (reset)
    !(in_fire && state_q == ST_FULL));

  a_skid_matches_state : assert property (@(posedge clk) disable iff (reset)
    skid_valid == (state_q == ST_FULL));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, bubble
// sequence, and randomized traffic against a queue-based reference model.
module tb_pipe_stage_skid;

  localparam int          DW = 128;
  localparam int          CW = 12;
  localparam logic [DW-1:0] RD = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .RESET_DATA(RD)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          iv;
    logic [DW-1:0] id;
    logic          fl;
    logic          ordy;
    logic          eov;
    logic [DW-1:0] eod;
    logic [1:0]    eocc;
    logic          eir;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } ent_t;

  vec_t vecs[$];
  ent_t model_q[$];
  logic [DW-1:0] model_last;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_ctrl(input logic [DW-1:0] d);
    return {4'h3, d[7:0]};
  endfunction

  task automatic add(input logic rst, input logic iv, input logic [DW-1:0] id,
                     input logic fl, input logic ordy, input logic eov,
                     input logic [DW-1:0] eod, input logic [1:0] eocc, input logic eir);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.fl = fl; v.ordy = ordy;
    v.eov = eov; v.eod = eod; v.eocc = eocc; v.eir = eir;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic eov, input logic [DW-1:0] eod,
                               input logic [CW-1:0] eoc, input logic [1:0] eocc, input logic eir);
    check({tag, " out_valid"}, DW'(out_valid), DW'(eov));
    check({tag, " out_data"},  out_data, eod);
    check({tag, " out_ctrl"},  DW'(out_ctrl), DW'(eoc));
    check({tag, " occupancy"}, DW'(occupancy), DW'(eocc));
    check({tag, " in_ready"},  DW'(in_ready), DW'(eir));
  endtask

  initial begin
    int p_in, p_out;
    logic          exp_ov, exp_ir, fire_in, fire_out;
    logic [DW-1:0] exp_od;
    logic [CW-1:0] exp_oc;
    ent_t e;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // rst iv  data   fl rdy | ov  data   occ ir   (outputs seen before the edge)
    add(1, 0, 0,      0, 0,    0, RD,     0, 0);
    add(0, 1, 'h11,   0, 1,    0, RD,     0, 1);
    for (int k = 1; k < 8; k++)
      add(0, 1, DW'('h11 + k), 0, 1, 1, DW'('h10 + k), 1, 1);
    add(0, 0, 0,      0, 1,    1, 'h18,   1, 1);
    add(0, 0, 0,      0, 1,    0, 'h18,   0, 1);
    add(0, 1, 'hA1,   0, 0,    0, 'h18,   0, 1);
    add(0, 1, 'hA2,   0, 0,    1, 'hA1,   1, 1);
    add(0, 1, 'hA3,   0, 0,    1, 'hA1,   2, 0);
    add(0, 0, 0,      0, 1,    1, 'hA1,   2, 0);
    add(0, 0, 0,      0, 1,    1, 'hA2,   1, 1);
    add(0, 0, 0,      0, 0,    0, 'hA2,   0, 1);
    add(0, 1, 'hB1,   0, 0,    0, 'hA2,   0, 1);
    add(0, 1, 'hB2,   0, 0,    1, 'hB1,   1, 1);
    add(0, 1, 'hB3,   1, 1,    1, 'hB1,   2, 0);
    add(0, 0, 0,      0, 1,    0, RD,     0, 1);
    add(0, 1, 'hC1,   0, 1,    0, RD,     0, 1);
    add(0, 1, 'hC2,   1, 1,    1, 'hC1,   1, 1);
    add(0, 0, 0,      0, 1,    0, RD,     0, 1);
    add(0, 1, 'hD1,   0, 0,    0, RD,     0, 1);
    add(0, 1, 'hD2,   0, 0,    1, 'hD1,   1, 1);
    add(1, 1, 'hD3,   0, 1,    1, 'hD1,   2, 0);
    add(1, 0, 0,      0, 0,    0, RD,     0, 0);
    add(0, 0, 0,      0, 1,    0, RD,     0, 1);
    add(0, 1, 'hE1,   0, 1,    0, RD,     0, 1);
    add(0, 0, 0,      0, 1,    1, 'hE1,   1, 1);
    add(0, 0, 0,      0, 1,    0, 'hE1,   0, 1);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      reset = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].id;
      in_ctrl = mk_ctrl(vecs[i].id); flush = vecs[i].fl; out_ready = vecs[i].ordy;
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].eov, vecs[i].eod,
                    vecs[i].eov ? mk_ctrl(vecs[i].eod) : '0, vecs[i].eocc, vecs[i].eir);
    end

    // Bubble: all-ones control offered without in_valid must never leak out.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0; in_ctrl = '1; flush = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check_outputs($sformatf("bubble%0d", k), 1'b0, 'hE1, '0, 2'd0, 1'b1);
    end

    // Randomized traffic against a FIFO-of-entries model.
    @(posedge clk); #1; reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    model_q.delete();
    model_last = RD;
    p_in = 50; p_out = 50;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc % 500 == 0) begin
        p_in  = 25 * $urandom_range(1, 4);
        p_out = 25 * $urandom_range(0, 4);
      end
      @(posedge clk); #1;
      reset     = ($urandom_range(999) == 0);
      flush     = ($urandom_range(99) == 0);
      in_valid  = ($urandom_range(99) < p_in);
      out_ready = ($urandom_range(99) < p_out);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_ctrl   = CW'($urandom);
      @(negedge clk);

      exp_ov = (model_q.size() != 0);
      exp_od = exp_ov ? model_q[0].data : model_last;
      exp_oc = exp_ov ? model_q[0].ctrl : '0;
      exp_ir = !reset && (model_q.size() < 2);
      check_outputs($sformatf("rnd%0d", cyc), exp_ov, exp_od, exp_oc, 2'(model_q.size()), exp_ir);

      if (reset || flush) begin
        model_q.delete();
        model_last = RD;
      end else begin
        fire_in  = in_valid && exp_ir;
        fire_out = exp_ov && out_ready;
        if (fire_out) begin
          model_last = model_q[0].data;
          void'(model_q.pop_front());
        end
        if (fire_in) begin
          e.data = in_data;
          e.ctrl = in_ctrl;
          model_q.push_back(e);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
